io_input_cond: RTL and testbench
================================

// Module: io_input_cond
// PURPOSE
//  Input conditioner between board pins and the pipelined core's sw/btn inputs.
//  Synchronises switches and synchronises + debounces the push-buttons (pins are active-low).
//  Emits clean active-high button levels, 1-cycle press pulses and sticky press flags.
//  Software clears the sticky flags write-1-to-clear through the core's I/O store path.
// PARAMETERS
//  SW_W     32     switch width
//  BTN_W    4      button width
//  DEB_CNT  50000  consecutive stable samples needed to accept a button change (>=1; bench uses 4)
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  sw_i         in   SW_W   raw switch pins (asynchronous)
//  btn_i        in   BTN_W  raw button pins, active-low (0 = pressed), asynchronous
//  clr_i        in   BTN_W  write-1-to-clear mask for btn_press_o, 1-cycle strobe from core
//  sw_o         out  SW_W   synchronised switches
//  btn_o        out  BTN_W  debounced button level, active-high (1 = pressed)
//  btn_pulse_o  out  BTN_W  1-cycle pulse on debounced press (0->1 of btn_o)
//  btn_press_o  out  BTN_W  sticky press flags
// BEHAVIOUR
//  Reset (rst=1 at an edge): sync flops, debounce state and all outputs go to 0; counters go to 0.
//   Button sync flops load 1 (released pin level), so no false press appears after reset.
//  Switches: two-flop synchroniser, no debounce; sw_o = 2nd flop.
//   A pin change before edge E0 is visible on sw_o after E1 (latency 2).
//  Buttons, per bit, independent: two-flop sync, then invert -> s (1 = pressed).
//   Debounce state: stable (= btn_o) and cnt, width $clog2(DEB_CNT+1).
//   Each edge, if s == stable: cnt <= 0.
//   Each edge, if s != stable and cnt == DEB_CNT-1: stable <= s and cnt <= 0.
//   Each edge, if s != stable otherwise: cnt <= cnt+1.
//   A held pin change before E0 updates btn_o at edge E(DEB_CNT+1), the (DEB_CNT+2)th edge.
//   A disagreement lasting fewer than DEB_CNT sampled cycles is discarded; cnt restarts from 0.
//   No wrap: cnt never exceeds DEB_CNT-1.
//  btn_pulse_o[i] is 1 for exactly the cycle after the edge where stable[i] goes 0->1.
//   It is registered and updates on the same edge as btn_o; release (1->0) produces no pulse.
//  btn_press_o[i] is set on the same edge btn_pulse_o[i] asserts.
//   clr_i[i]=1 clears btn_press_o[i] at the next edge.
//   If set and clear land on the same edge, set wins and the flag stays 1.
//   clr_i on a bit whose flag is already 0 has no effect.
//  Reset mid-debounce aborts the count; no pulse and no flag result.
//  No handshake; every output is registered and glitch-free.
// STRUCTURE
//  io_pkg (shared package):
//   SW_W_DEF=32, BTN_W_DEF=4, DEB_CNT_BOARD=50000, DEB_CNT_SIM=4.
//   Function cnt_w(n) = $clog2(n+1).
//  Sub-module io_debounce: one bit; sync, counter, stable, pulse, sticky.
//   Generated BTN_W times.
//  Switch synchroniser is inline in io_input_cond.
// TESTING  (DEB_CNT=4, BTN_W=4, SW_W=32)
//  1 rst=1 for 3 edges, btn_i=4'hF, sw_i=32'hFFFF_FFFF:
//    all outputs 0 during reset; sw_o=32'hFFFF_FFFF 2 edges after rst drops; btn_o stays 0.
//  2 sw_i 32'd123456 -> 32'd2 before E0: sw_o=2 after E1, not after E0.
//  3 btn_i[0]=0 held from before E0:
//    btn_o[0]=1 after E5; btn_pulse_o=4'b0001 only after E5; btn_press_o[0]=1 from E5 on.
//  4 btn_i[1]=0 for 3 cycles then 1: btn_o, btn_pulse_o, btn_press_o stay 0.
//    btn_i[1]=0 for exactly 4 cycles: btn_o[1] pulses high.
//  5 clr_i=4'b0001 on the same edge bit0's press is accepted: btn_press_o[0] stays 1.
//    clr_i=4'b0001 alone 3 cycles later: btn_press_o[0]=0 after that edge.
//  6 btn_i[0] back to 1 with btn_o[0]=1: btn_o[0]=0 after 6 edges, no pulse, sticky unchanged.
//    Assert rst at edge 3 of a new press: nothing set, all outputs 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants and helpers for the board I/O conditioning blocks.
package io_pkg;

    localparam int SW_W_DEF      = 32;
    localparam int BTN_W_DEF     = 4;
    localparam int DEB_CNT_BOARD = 50000;
    localparam int DEB_CNT_SIM   = 4;

    // Bits needed to hold a count of 0..n.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/io_debounce.sv
// One push-button lane: two-flop synchroniser, debounce counter, press pulse and
// write-1-to-clear sticky press flag. The pin is active-low; all outputs are active-high.
module io_debounce
    import io_pkg::*;
#(
    parameter int DEB_CNT = DEB_CNT_BOARD
) (
    input  logic clk,
    input  logic rst,
    input  logic pin_n,
    input  logic clr,
    output logic level,
    output logic pulse,
    output logic press
);

    localparam int             CW       = cnt_w(DEB_CNT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEB_CNT - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          s;
    logic          accept;
    logic          rise;

    assign s      = ~sync2;
    assign accept = (s != level) && (cnt == CNT_LAST);
    assign rise   = accept && s;

    // NOTE: every flop here updates with <= so all of them sample the values from
    // before the edge; blocking = would let sync2 see this edge's sync1.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Sync flops hold the released pin level so leaving reset is not a press.
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            level <= 1'b0;
            cnt   <= '0;
            pulse <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= pin_n;
            sync2 <= sync1;

            if (s == level) begin
                cnt <= '0;
            end else if (accept) begin
                level <= s;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end

            pulse <= rise;
            // A new press outranks a clear landing on the same edge.
            press <= rise | (press & ~clr);
        end
    end

endmodule

// File: rtl/io_input_cond.sv
// Input conditioner between board pins and the core: synchronised switches and
// debounced, active-high buttons with press pulses and sticky press flags.
module io_input_cond
    import io_pkg::*;
#(
    parameter int SW_W    = SW_W_DEF,
    parameter int BTN_W   = BTN_W_DEF,
    parameter int DEB_CNT = DEB_CNT_BOARD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  sw_i,
    input  logic [BTN_W-1:0] btn_i,
    input  logic [BTN_W-1:0] clr_i,
    output logic [SW_W-1:0]  sw_o,
    output logic [BTN_W-1:0] btn_o,
    output logic [BTN_W-1:0] btn_pulse_o,
    output logic [BTN_W-1:0] btn_press_o
);

    logic [SW_W-1:0] sw_s1;

    // Switches are slow-moving levels, so synchronising without debounce is enough.
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_s1 <= '0;
            sw_o  <= '0;
        end else begin
            sw_s1 <= sw_i;
            sw_o  <= sw_s1;
        end
    end

    for (genvar i = 0; i < BTN_W; i++) begin : g_btn
        io_debounce #(
            .DEB_CNT(DEB_CNT)
        ) u_deb (
            .clk  (clk),
            .rst  (rst),
            .pin_n(btn_i[i]),
            .clr  (clr_i[i]),
            .level(btn_o[i]),
            .pulse(btn_pulse_o[i]),
            .press(btn_press_o[i])
        );
    end

endmodule

// File: tb/tb_io_input_cond.sv
// Directed bench for io_input_cond with a short debounce window: per-edge vector
// table for reset, switches and a first press, then hand sequences for the corners.
module tb_io_input_cond;
    import io_pkg::*;

    localparam int SW_W  = 32;
    localparam int BTN_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [SW_W-1:0]  sw_i;
    logic [BTN_W-1:0] btn_i;
    logic [BTN_W-1:0] clr_i;
    logic [SW_W-1:0]  sw_o;
    logic [BTN_W-1:0] btn_o;
    logic [BTN_W-1:0] btn_pulse_o;
    logic [BTN_W-1:0] btn_press_o;

    io_input_cond #(
        .SW_W   (SW_W),
        .BTN_W  (BTN_W),
        .DEB_CNT(DEB_CNT_SIM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw_i       (sw_i),
        .btn_i      (btn_i),
        .clr_i      (clr_i),
        .sw_o       (sw_o),
        .btn_o      (btn_o),
        .btn_pulse_o(btn_pulse_o),
        .btn_press_o(btn_press_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [31:0] sw;
        logic [3:0]  btn;
        logic [3:0]  clr;
        logic [31:0] e_sw;
        logic [3:0]  e_btn;
        logic [3:0]  e_pulse;
        logic [3:0]  e_press;
        string       name;
    } vec_t;

    vec_t        tbl[$];
    int          n_vec = 0;
    int          n_bad = 0;
    logic [31:0] sw_exp;

    task automatic add(input logic r, input logic [31:0] sw, input logic [3:0] b,
                       input logic [3:0] c, input logic [31:0] esw, input logic [3:0] eb,
                       input logic [3:0] ep, input logic [3:0] epr, input string nm);
        vec_t v;
        v = '{r, sw, b, c, esw, eb, ep, epr, nm};
        tbl.push_back(v);
    endtask

    task automatic check(input string name, input logic [43:0] act, input logic [43:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got sw=%h btn=%b pulse=%b press=%b, want sw=%h btn=%b pulse=%b press=%b",
                     name, act[43:12], act[11:8], act[7:4], act[3:0],
                     exp[43:12], exp[11:8], exp[7:4], exp[3:0]);
        end
    endtask

    // One rising edge, then compare all outputs 1 time unit later.
    task automatic tick(input string name, input logic [3:0] eb, input logic [3:0] ep,
                        input logic [3:0] epr);
        @(posedge clk);
        #1;
        check(name, {sw_o, btn_o, btn_pulse_o, btn_press_o}, {sw_exp, eb, ep, epr});
    endtask

    task automatic run(input string name, input int n, input logic [3:0] eb,
                       input logic [3:0] ep, input logic [3:0] epr);
        for (int i = 0; i < n; i++) tick($sformatf("%s[%0d]", name, i), eb, ep, epr);
    endtask

    initial begin
        rst   = 1'b1;
        sw_i  = 32'hFFFF_FFFF;
        btn_i = 4'hF;
        clr_i = 4'h0;

        // Reset, switch latency, first debounced press of bit 0.
        for (int i = 0; i < 3; i++)
            add(1'b1, 32'hFFFF_FFFF, 4'hF, 4'h0, 32'h0, 4'h0, 4'h0, 4'h0, $sformatf("rst%0d", i));
        add(1'b0, 32'hFFFF_FFFF, 4'hF, 4'h0, 32'h0,         4'h0, 4'h0, 4'h0, "post_rst_e0");
        add(1'b0, 32'hFFFF_FFFF, 4'hF, 4'h0, 32'hFFFF_FFFF, 4'h0, 4'h0, 4'h0, "post_rst_e1");
        add(1'b0, 32'd123456,    4'hF, 4'h0, 32'hFFFF_FFFF, 4'h0, 4'h0, 4'h0, "sw_a_e0");
        add(1'b0, 32'd123456,    4'hF, 4'h0, 32'd123456,    4'h0, 4'h0, 4'h0, "sw_a_e1");
        add(1'b0, 32'd2,         4'hF, 4'h0, 32'd123456,    4'h0, 4'h0, 4'h0, "sw_b_e0");
        add(1'b0, 32'd2,         4'hF, 4'h0, 32'd2,         4'h0, 4'h0, 4'h0, "sw_b_e1");
        for (int i = 0; i < 5; i++)
            add(1'b0, 32'd2, 4'hE, 4'h0, 32'd2, 4'h0, 4'h0, 4'h0, $sformatf("press0_e%0d", i));
        add(1'b0, 32'd2, 4'hE, 4'h0, 32'd2, 4'h1, 4'h1, 4'h1, "press0_e5");
        add(1'b0, 32'd2, 4'hE, 4'h0, 32'd2, 4'h1, 4'h0, 4'h1, "press0_e6");
        add(1'b0, 32'd2, 4'hE, 4'h0, 32'd2, 4'h1, 4'h0, 4'h1, "press0_e7");

        foreach (tbl[k]) begin
            rst    = tbl[k].rst;
            sw_i   = tbl[k].sw;
            btn_i  = tbl[k].btn;
            clr_i  = tbl[k].clr;
            sw_exp = tbl[k].e_sw;
            tick(tbl[k].name, tbl[k].e_btn, tbl[k].e_pulse, tbl[k].e_press);
        end

        // Release bit 0: level drops on the sixth edge, no pulse, flag kept.
        sw_exp = 32'd2;
        btn_i  = 4'hF;
        run("release0", 5, 4'h1, 4'h0, 4'h1);
        tick("release0_e5", 4'h0, 4'h0, 4'h1);

        // Write-1-to-clear, then set-wins when press and clear share an edge.
        clr_i = 4'h1;
        tick("clr0", 4'h0, 4'h0, 4'h0);
        clr_i = 4'h0;
        btn_i = 4'hE;
        run("repress0", 5, 4'h0, 4'h0, 4'h0);
        clr_i = 4'h1;
        tick("repress0_setwins", 4'h1, 4'h1, 4'h1);
        clr_i = 4'h0;
        tick("repress0_e6", 4'h1, 4'h0, 4'h1);
        clr_i = 4'h4;
        tick("clr2_noeffect", 4'h1, 4'h0, 4'h1);
        clr_i = 4'h1;
        tick("clr0_late", 4'h1, 4'h0, 4'h0);
        clr_i = 4'h0;

        // Bit 1 glitch of 3 cycles is discarded; exactly 4 cycles is accepted.
        btn_i = 4'hC;
        run("glitch1_lo", 3, 4'h1, 4'h0, 4'h0);
        btn_i = 4'hE;
        run("glitch1_hi", 4, 4'h1, 4'h0, 4'h0);
        btn_i = 4'hC;
        run("pulse1_lo", 4, 4'h1, 4'h0, 4'h0);
        btn_i = 4'hE;
        tick("pulse1_e4", 4'h1, 4'h0, 4'h0);
        tick("pulse1_e5", 4'h3, 4'h2, 4'h2);
        run("pulse1_hold", 3, 4'h3, 4'h0, 4'h2);
        tick("pulse1_drop", 4'h1, 4'h0, 4'h2);

        // Reset on the fourth edge of a new bit-2 press aborts it.
        btn_i = 4'hA;
        run("abort2", 3, 4'h1, 4'h0, 4'h2);
        rst    = 1'b1;
        sw_exp = 32'd0;
        tick("abort2_rst", 4'h0, 4'h0, 4'h0);
        rst   = 1'b0;
        btn_i = 4'hF;
        tick("after_rst_e0", 4'h0, 4'h0, 4'h0);
        sw_exp = 32'd2;
        run("after_rst", 6, 4'h0, 4'h0, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
